// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the rv32i MEM stage: FSM states, load/store funct3 codes and the
// EX/MEM and MEM/WB pipeline register layouts.
package mem_stage_ctrl_pkg;

  // Pipeline registers are sized for the widest data bus; narrower buses use the low lanes.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_MASK_W = MAX_DATA_W / 8;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_fsm_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic [31:0]           alu_out;
    logic [31:0]           mem_addr;
    logic [MAX_MASK_W-1:0] rmask;
    logic [MAX_MASK_W-1:0] wmask;
    logic [MAX_DATA_W-1:0] wdata;
    logic [4:0]            rd_addr;
    logic                  regf_we;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic [31:0]           alu_out;
    logic [31:0]           mem_addr;
    logic [MAX_MASK_W-1:0] rmask;
    logic [MAX_MASK_W-1:0] wmask;
    logic [MAX_DATA_W-1:0] wdata;
    logic [4:0]            rd_addr;
    logic                  regf_we;
    logic [31:0]           mem_rdata;
    logic                  mem_fault;
  } mem_wb_stage_reg_t;

  // The low two funct3 bits give the access size for loads and stores alike.
  function automatic logic accessMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    return ((funct3[1:0] == F3_SH[1:0]) && addrLo[0]) ||
           ((funct3[1:0] == F3_SW[1:0]) && (addrLo != 2'b00));
  endfunction

  function automatic mem_wb_stage_reg_t toMemWb(input ex_mem_stage_reg_t ex,
                                                input logic [31:0]       rdata,
                                                input logic              fault,
                                                input logic              clearMasks);
    mem_wb_stage_reg_t wb;
    wb.valid     = ex.valid;
    wb.pc        = ex.pc;
    wb.inst      = ex.inst;
    wb.alu_out   = ex.alu_out;
    wb.mem_addr  = ex.mem_addr;
    wb.rmask     = clearMasks ? '0 : ex.rmask;
    wb.wmask     = clearMasks ? '0 : ex.wmask;
    wb.wdata     = ex.wdata;
    wb.rd_addr   = ex.rd_addr;
    wb.regf_we   = ex.regf_we;
    wb.mem_rdata = rdata;
    wb.mem_fault = fault;
    return wb;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_align.sv
// Combinational load formatter: shifts the addressed lane down and sign/zero-extends it
// according to the load funct3.
module mem_stage_ctrl_load_align
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]            rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0]  offset_i,
  input  logic [2:0]                   funct3_i,
  output logic [31:0]                  data_o
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data_o = {24'h000000, shifted[7:0]};
      F3_LHU:  data_o = {16'h0000, shifted[15:0]};
      F3_LW:   data_o = shifted[31:0];
      default: data_o = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle MEM stage: issues one dmem request per memory instruction, stalls the
// pipeline until the response (or timeout) and hands the result to the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RESP_TIMEOUT = 0,
  parameter int TMO_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  ex_mem_stage_reg_t   ex_mem_stage_reg_i,
  output mem_wb_stage_reg_t   mem_wb_stage_reg_o,
  output logic                mem_stall_o,
  output logic [31:0]         dmem_addr_o,
  output logic [DATA_W/8-1:0] dmem_rmask_o,
  output logic [DATA_W/8-1:0] dmem_wmask_o,
  output logic [DATA_W-1:0]   dmem_wdata_o,
  input  logic [DATA_W-1:0]   dmem_rdata_i,
  input  logic                dmem_resp_i,
  output logic                mem_misaligned_o,
  output logic                mem_timeout_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(MASK_W);

  mem_fsm_state_t    state_q, state_d;
  ex_mem_stage_reg_t holdReg_q, holdReg_d;
  logic [TMO_W-1:0]  tmoCnt_q, tmoCnt_d;
  logic              timeout_q, timeout_d;

  ex_mem_stage_reg_t exIn;
  logic              isMemOp;
  logic              isMisaligned;
  logic              tmoHit;
  logic [31:0]       loadData;
  logic [31:0]       respData;

  assign exIn         = ex_mem_stage_reg_i;
  assign isMemOp      = exIn.valid && ((exIn.rmask[MASK_W-1:0] | exIn.wmask[MASK_W-1:0]) != '0);
  assign isMisaligned = accessMisaligned(exIn.inst[14:12], exIn.mem_addr[1:0]);
  assign tmoHit       = (RESP_TIMEOUT > 0) && (tmoCnt_q == TMO_W'(RESP_TIMEOUT - 1));

  mem_stage_ctrl_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .rdata_i (dmem_rdata_i),
    .offset_i(holdReg_q.mem_addr[OFF_W-1:0]),
    .funct3_i(holdReg_q.inst[14:12]),
    .data_o  (loadData)
  );

  // Stores report the raw response word; only loads get lane formatting.
  assign respData      = (holdReg_q.rmask[MASK_W-1:0] != '0) ? loadData : dmem_rdata_i[31:0];
  assign mem_timeout_o = timeout_q;

  // Request, stall and result paths are combinational so a request issues in the same
  // cycle the instruction arrives and the pipeline resumes in the response cycle.
  // Reset forces every output low immediately, even mid-transaction.
  always_comb begin
    state_d            = state_q;
    holdReg_d          = holdReg_q;
    tmoCnt_d           = tmoCnt_q;
    timeout_d          = timeout_q;
    mem_wb_stage_reg_o = '0;
    mem_stall_o        = 1'b0;
    dmem_addr_o        = '0;
    dmem_rmask_o       = '0;
    dmem_wmask_o       = '0;
    dmem_wdata_o       = '0;
    mem_misaligned_o   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (isMemOp && isMisaligned) begin
            mem_misaligned_o   = 1'b1;
            mem_wb_stage_reg_o = toMemWb(exIn, '0, 1'b1, 1'b1);
          end else if (isMemOp) begin
            dmem_addr_o        = exIn.mem_addr & ~32'(MASK_W - 1);
            dmem_rmask_o       = exIn.rmask[MASK_W-1:0];
            dmem_wmask_o       = exIn.wmask[MASK_W-1:0];
            dmem_wdata_o       = exIn.wdata[DATA_W-1:0];
            mem_stall_o        = 1'b1;
            mem_wb_stage_reg_o = toMemWb(exIn, '0, 1'b0, 1'b0);
            holdReg_d          = exIn;
            tmoCnt_d           = '0;
            state_d            = WAIT;
          end else begin
            mem_wb_stage_reg_o = toMemWb(exIn, '0, 1'b0, 1'b0);
          end
        end
        WAIT: begin
          mem_stall_o        = 1'b1;
          mem_wb_stage_reg_o = toMemWb(holdReg_q, '0, 1'b0, 1'b0);
          tmoCnt_d           = tmoCnt_q + 1'b1;
          if (dmem_resp_i) begin
            mem_stall_o        = 1'b0;
            mem_wb_stage_reg_o = toMemWb(holdReg_q, respData, 1'b0, 1'b0);
            tmoCnt_d           = '0;
            state_d            = IDLE;
          end else if (tmoHit) begin
            mem_stall_o        = 1'b0;
            mem_wb_stage_reg_o = toMemWb(holdReg_q, '0, 1'b1, 1'b0);
            tmoCnt_d           = '0;
            timeout_d          = 1'b1;
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      holdReg_q <= '0;
      tmoCnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdReg_q <= holdReg_d;
      tmoCnt_q  <= tmoCnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
